// File: rtl/sram_req_arbiter_if.sv
// SRAM-like request/response port: one address phase (req/addr_ok) and one
// in-order response phase (data_ok/rdata). The master side issues requests.
interface sram_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_req_arbiter.sv
// Two-to-one SRAM-like port arbiter: the instruction-fetch and data requesters
// share one downstream port. Data wins address-phase ties, and a grant stays
// frozen until addr_ok. An in-order ID FIFO sends each response back to the
// requester that issued it.
module sram_req_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    sram_req_arbiter_if.slave        inst_if,
    sram_req_arbiter_if.slave        data_if,
    sram_req_arbiter_if.master       m_if,
    output logic                     idle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Grant lock: free, frozen on fetch, or frozen on data.
    typedef enum logic [1:0] {
        ST_FREE      = 2'd0,
        ST_LOCK_INST = 2'd1,
        ST_LOCK_DATA = 2'd2
    } state_e;

    state_e             state_r;
    state_e             state_nxt_s;

    logic [DEPTH-1:0]   fifo_r;      // requester ID per outstanding transaction
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               full_r;

    logic               lock_s;
    logic               lock_id_s;
    logic               sel_s;       // 0 = inst, 1 = data
    logic               m_req_s;
    logic               push_s;
    logic               pop_s;
    logic               head_s;
    logic               empty_s;

    // Decode the lock state into the lock flag and the locked requester.
    always_comb begin
        lock_s    = 1'b0;
        lock_id_s = 1'b0;
        case (state_r)
            ST_FREE: begin
                lock_s    = 1'b0;
                lock_id_s = 1'b0;
            end
            ST_LOCK_INST: begin
                lock_s    = 1'b1;
                lock_id_s = 1'b0;
            end
            ST_LOCK_DATA: begin
                lock_s    = 1'b1;
                lock_id_s = 1'b1;
            end
            default: begin
                lock_s    = 1'b0;
                lock_id_s = 1'b0;
            end
        endcase
    end

    // Requester selection and the handshake events. A held lock overrides
    // the data-first tie rule. Handshakes are masked while reset is asserted,
    // so no addr_ok/data_ok escapes during reset.
    always_comb begin
        sel_s   = 1'b0;
        m_req_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        empty_s = (count_r == {CNT_W{1'b0}});
        head_s  = fifo_r[rd_ptr_r];
        if (lock_s) begin
            sel_s = lock_id_s;
        end else begin
            sel_s = data_if.req;
        end
        m_req_s = ~full_r & (lock_s | inst_if.req | data_if.req);
        push_s  = resetn & m_req_s & m_if.addr_ok;
        pop_s   = resetn & m_if.data_ok & ~empty_s;
    end

    // Lock state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_FREE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next lock state. Acceptance releases the lock, and an unaccepted request
    // freezes the grant on the current selection.
    always_comb begin
        state_nxt_s = state_r;
        if (push_s) begin
            state_nxt_s = ST_FREE;
        end else if (m_req_s) begin
            if (sel_s) begin
                state_nxt_s = ST_LOCK_DATA;
            end else begin
                state_nxt_s = ST_LOCK_INST;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Occupancy after this cycle's push/pop. A simultaneous push and pop
    // leave the count unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // ID FIFO storage, pointers, count and the registered full flag. Because
    // full is registered, a pop frees a slot for the next cycle only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_r   <= {DEPTH{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= sel_s;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
        end
    end

    // Downstream fields follow the selection even when no request is
    // presented. Responses are steered by the FIFO head, and read data passes
    // straight through.
    always_comb begin
        m_if.req   = m_req_s;
        m_if.wr    = 1'b0;
        m_if.size  = 2'b00;
        m_if.addr  = 32'h0000_0000;
        m_if.wstrb = 4'h0;
        m_if.wdata = 32'h0000_0000;
        if (sel_s) begin
            m_if.wr    = data_if.wr;
            m_if.size  = data_if.size;
            m_if.addr  = data_if.addr;
            m_if.wstrb = data_if.wstrb;
            m_if.wdata = data_if.wdata;
        end else begin
            m_if.wr    = inst_if.wr;
            m_if.size  = inst_if.size;
            m_if.addr  = inst_if.addr;
            m_if.wstrb = inst_if.wstrb;
            m_if.wdata = inst_if.wdata;
        end
        inst_if.addr_ok = push_s & ~sel_s;
        data_if.addr_ok = push_s & sel_s;
        inst_if.data_ok = pop_s & ~head_s;
        data_if.data_ok = pop_s & head_s;
        inst_if.rdata   = m_if.rdata;
        data_if.rdata   = m_if.rdata;
        idle            = ~lock_s & empty_s;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter. A queue-based reference model is
// checked on every falling edge, and literal expectations pin key points.
module tb_sram_req_arbiter;

    localparam int DEPTH = 2;

    logic clk;
    logic resetn;
    logic idle;

    sram_req_arbiter_if inst_b ();
    sram_req_arbiter_if data_b ();
    sram_req_arbiter_if m_b ();

    sram_req_arbiter #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .inst_if (inst_b),
        .data_if (data_b),
        .m_if    (m_b),
        .idle    (idle)
    );

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lock flag, locked requester, and a queue of IDs.
    bit mdl_lock;
    bit mdl_lock_id;
    bit mdl_q[$];

    always @(negedge clk) begin
        bit sel;
        bit mreq;
        bit hs;
        bit pop;
        bit head;
        if (!resetn) begin
            mdl_lock    = 1'b0;
            mdl_lock_id = 1'b0;
            mdl_q.delete();
        end
        sel  = mdl_lock ? mdl_lock_id : data_b.req;
        mreq = (mdl_q.size() < DEPTH) && (mdl_lock || inst_b.req || data_b.req);
        hs   = resetn && mreq && m_b.addr_ok;
        pop  = resetn && m_b.data_ok && (mdl_q.size() > 0);
        head = (mdl_q.size() > 0) ? mdl_q[0] : 1'b0;
        check("m_req",   32'(m_b.req),   32'(mreq));
        check("m_addr",  m_b.addr,       sel ? data_b.addr : inst_b.addr);
        check("m_wr",    32'(m_b.wr),    32'(sel ? data_b.wr : inst_b.wr));
        check("m_size",  32'(m_b.size),  32'(sel ? data_b.size : inst_b.size));
        check("m_wstrb", 32'(m_b.wstrb), 32'(sel ? data_b.wstrb : inst_b.wstrb));
        check("m_wdata", m_b.wdata,      sel ? data_b.wdata : inst_b.wdata);
        check("inst_addr_ok", 32'(inst_b.addr_ok), 32'(hs && !sel));
        check("data_addr_ok", 32'(data_b.addr_ok), 32'(hs && sel));
        check("inst_data_ok", 32'(inst_b.data_ok), 32'(pop && !head));
        check("data_data_ok", 32'(data_b.data_ok), 32'(pop && head));
        check("inst_rdata", inst_b.rdata, m_b.rdata);
        check("data_rdata", data_b.rdata, m_b.rdata);
        check("idle", 32'(idle), 32'(!mdl_lock && (mdl_q.size() == 0)));
        if (resetn) begin
            if (pop) void'(mdl_q.pop_front());
            if (hs) mdl_q.push_back(sel);
            if (hs) begin
                mdl_lock = 1'b0;
            end else if (mreq) begin
                mdl_lock    = 1'b1;
                mdl_lock_id = sel;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        inst_b.req = 1'b0; inst_b.wr = 1'b0; inst_b.size = 2'd2; inst_b.addr = 32'h0;
        inst_b.wstrb = 4'h0; inst_b.wdata = 32'h0;
        data_b.req = 1'b0; data_b.wr = 1'b0; data_b.size = 2'd2; data_b.addr = 32'h0;
        data_b.wstrb = 4'h0; data_b.wdata = 32'h0;
        m_b.addr_ok = 1'b0; m_b.data_ok = 1'b0; m_b.rdata = 32'h0;
        tick(); tick();
        #1;
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_m_req", 32'(m_b.req), 32'd0);
        resetn = 1'b1;
        tick();

        // Single fetch.
        inst_b.req = 1'b1; inst_b.addr = 32'h1c00_0000; m_b.addr_ok = 1'b1;
        #1;
        check("t1_addr_ok", 32'(inst_b.addr_ok), 32'd1);
        check("t1_m_addr", m_b.addr, 32'h1c00_0000);
        tick();
        inst_b.req = 1'b0; m_b.addr_ok = 1'b0;
        #1;
        check("t1_busy", 32'(idle), 32'd0);
        tick();
        m_b.data_ok = 1'b1; m_b.rdata = 32'h0280_0000;
        #1;
        check("t1_data_ok", 32'(inst_b.data_ok), 32'd1);
        check("t1_rdata", inst_b.rdata, 32'h0280_0000);
        check("t1_no_ddok", 32'(data_b.data_ok), 32'd0);
        tick();
        m_b.data_ok = 1'b0;
        #1;
        check("t1_idle", 32'(idle), 32'd1);

        // Tie: data first, inst the following cycle.
        inst_b.req = 1'b1; inst_b.addr = 32'h1c00_0004;
        data_b.req = 1'b1; data_b.addr = 32'h0000_0800; data_b.wr = 1'b1;
        data_b.wstrb = 4'hF; data_b.wdata = 32'h1234_5678; m_b.addr_ok = 1'b1;
        #1;
        check("t2_m_addr", m_b.addr, 32'h0000_0800);
        check("t2_m_wr", 32'(m_b.wr), 32'd1);
        check("t2_daok", 32'(data_b.addr_ok), 32'd1);
        check("t2_iaok0", 32'(inst_b.addr_ok), 32'd0);
        tick();
        data_b.req = 1'b0; data_b.wr = 1'b0; data_b.wstrb = 4'h0;
        #1;
        check("t2_iaok", 32'(inst_b.addr_ok), 32'd1);
        check("t2_m_addr_i", m_b.addr, 32'h1c00_0004);
        tick();
        inst_b.req = 1'b0; m_b.addr_ok = 1'b0;
        m_b.data_ok = 1'b1; m_b.rdata = 32'h1111_1111;
        #1;
        check("t2_ddok", 32'(data_b.data_ok), 32'd1);
        tick();
        m_b.rdata = 32'h2222_2222;
        #1;
        check("t2_idok", 32'(inst_b.data_ok), 32'd1);
        tick();
        m_b.data_ok = 1'b0;

        // Lock hold: inst address stays until accepted, data waits.
        inst_b.req = 1'b1; inst_b.addr = 32'h1c00_0010;
        tick();
        data_b.req = 1'b1; data_b.addr = 32'h0000_0900;
        #1;
        check("t3_hold1", m_b.addr, 32'h1c00_0010);
        tick();
        #1;
        check("t3_hold2", m_b.addr, 32'h1c00_0010);
        check("t3_no_daok", 32'(data_b.addr_ok), 32'd0);
        tick();
        m_b.addr_ok = 1'b1;
        #1;
        check("t3_iaok", 32'(inst_b.addr_ok), 32'd1);
        check("t3_daok0", 32'(data_b.addr_ok), 32'd0);
        tick();
        inst_b.req = 1'b0;
        #1;
        check("t3_m_addr_d", m_b.addr, 32'h0000_0900);
        check("t3_daok", 32'(data_b.addr_ok), 32'd1);
        tick();
        data_b.req = 1'b0; m_b.addr_ok = 1'b0;

        // Full: two outstanding, so no request until the cycle after a pop.
        inst_b.req = 1'b1; inst_b.addr = 32'h1c00_0020;
        #1;
        check("t4_full", 32'(m_b.req), 32'd0);
        tick();
        m_b.data_ok = 1'b1; m_b.rdata = 32'h3333_3333;
        #1;
        check("t4_pop_idok", 32'(inst_b.data_ok), 32'd1);
        check("t4_no_bypass", 32'(m_b.req), 32'd0);
        tick();
        m_b.data_ok = 1'b0;
        #1;
        check("t4_req_back", 32'(m_b.req), 32'd1);
        m_b.addr_ok = 1'b1;
        #1;
        check("t4_iaok", 32'(inst_b.addr_ok), 32'd1);
        tick();
        inst_b.req = 1'b0; m_b.addr_ok = 1'b0;
        m_b.data_ok = 1'b1; m_b.rdata = 32'h4444_4444;
        #1;
        check("t4_ddok", 32'(data_b.data_ok), 32'd1);
        tick();
        m_b.rdata = 32'h5555_5555;
        #1;
        check("t4_idok", 32'(inst_b.data_ok), 32'd1);
        tick();
        m_b.data_ok = 1'b0;

        // Ordering: data load, then inst.
        data_b.req = 1'b1; data_b.addr = 32'h0000_1000; m_b.addr_ok = 1'b1;
        tick();
        data_b.req = 1'b0; inst_b.req = 1'b1; inst_b.addr = 32'h1c00_0030;
        tick();
        inst_b.req = 1'b0; m_b.addr_ok = 1'b0;
        m_b.data_ok = 1'b1; m_b.rdata = 32'hAAAA_0000;
        #1;
        check("t5_ddok", 32'(data_b.data_ok), 32'd1);
        check("t5_drdata", data_b.rdata, 32'hAAAA_0000);
        check("t5_idok0", 32'(inst_b.data_ok), 32'd0);
        tick();
        m_b.rdata = 32'hBBBB_0000;
        #1;
        check("t5_idok", 32'(inst_b.data_ok), 32'd1);
        check("t5_irdata", inst_b.rdata, 32'hBBBB_0000);
        check("t5_ddok0", 32'(data_b.data_ok), 32'd0);
        tick();
        m_b.data_ok = 1'b0;

        // Async reset with one outstanding and a held lock.
        inst_b.req = 1'b1; inst_b.addr = 32'h1c00_0040; m_b.addr_ok = 1'b1;
        tick();
        inst_b.req = 1'b0; data_b.req = 1'b1; data_b.addr = 32'h0000_2000; m_b.addr_ok = 1'b0;
        tick();
        check("t6_busy", 32'(idle), 32'd0);
        data_b.req = 1'b0;
        resetn = 1'b0;
        #1;
        check("t6_rst_idle", 32'(idle), 32'd1);
        check("t6_rst_mreq", 32'(m_b.req), 32'd0);
        tick();
        resetn = 1'b1;
        m_b.data_ok = 1'b1; m_b.rdata = 32'hDEAD_BEEF;
        #1;
        check("t6_spur_i", 32'(inst_b.data_ok), 32'd0);
        check("t6_spur_d", 32'(data_b.data_ok), 32'd0);
        tick();
        m_b.data_ok = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
